// File: rtl/core_gen2_pkg.sv
// Shared constants for core_gen2: FSM state codes, opcode nibbles and ALU selectors.
// Pure definitions with no timing or flow-control behaviour.
package core_gen2_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_FETCH  = 3'd1;
  localparam logic [2:0] ST_DECODE = 3'd2;
  localparam logic [2:0] ST_IMM    = 3'd3;
  localparam logic [2:0] ST_EXEC   = 3'd4;
  localparam logic [2:0] ST_MEM    = 3'd5;
  localparam logic [2:0] ST_HALT   = 3'd6;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_LDAR = 4'h1;
  localparam logic [3:0] OP_MEM  = 4'h2;
  localparam logic [3:0] OP_ST   = 4'h3;
  localparam logic [3:0] OP_LD   = 4'h4;
  localparam logic [3:0] OP_ADD  = 4'h5;
  localparam logic [3:0] OP_SUB  = 4'h6;
  localparam logic [3:0] OP_MUL  = 4'h7;
  localparam logic [3:0] OP_INC  = 4'h8;
  localparam logic [3:0] OP_LDI  = 4'h9;
  localparam logic [3:0] OP_JZ   = 4'hA;
  localparam logic [3:0] OP_JNZ  = 4'hB;
  localparam logic [3:0] OP_JMP  = 4'hC;
  localparam logic [3:0] OP_CID  = 4'hD;
  localparam logic [3:0] OP_ERR  = 4'hE;
  localparam logic [3:0] OP_HALT = 4'hF;

  // Low-nibble sub-opcodes of the OP_MEM group
  localparam logic [3:0] SUB_LOAD  = 4'h0;
  localparam logic [3:0] SUB_STORE = 4'h1;
  localparam logic [3:0] SUB_INCAR = 4'h2;

  localparam logic [1:0] ALU_PASS = 2'd0;
  localparam logic [1:0] ALU_ADD  = 2'd1;
  localparam logic [1:0] ALU_SUB  = 2'd2;
  localparam logic [1:0] ALU_MUL  = 2'd3;

  function automatic logic [1:0] alu_sel(input logic [3:0] op);
    case (op)
      OP_ADD:  return ALU_ADD;
      OP_SUB:  return ALU_SUB;
      OP_MUL:  return ALU_MUL;
      default: return ALU_PASS;
    endcase
  endfunction

endpackage

// File: rtl/core_gen2_regfile.sv
// General register file: one synchronous write port, one combinational read port.
// Write lands on the next clk edge; no flow control.
module core_gen2_regfile #(
  parameter int DATA_W  = 16,
  parameter int NUM_GPR = 8,
  parameter int AW      = $clog2(NUM_GPR)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] regs [NUM_GPR];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_GPR; i++) regs[i] <= '0;
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata = regs[raddr];

endmodule

// File: rtl/core_gen2.sv
// Accumulator core: fetch/decode/execute over req/ack instruction and data ports.
// Reg/ALU op takes 3 cycles at zero wait; every handshake stretches by the ack delay.
module core_gen2
  import core_gen2_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 16,
  parameter int NUM_GPR = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        core_id,
  input  logic              start,
  output logic              im_req,
  output logic [ADDR_W-1:0] im_addr,
  input  logic              im_ack,
  input  logic [7:0]        im_rdata,
  output logic              dm_req,
  output logic              dm_we,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [DATA_W-1:0] dm_wdata,
  input  logic              dm_ack,
  input  logic [DATA_W-1:0] dm_rdata,
  output logic              halted,
  output logic              err
);

  localparam int GPR_AW    = $clog2(NUM_GPR);
  localparam int IMM_BYTES = DATA_W / 8;
  localparam int IMM_W     = (DATA_W > 16) ? DATA_W : 16;
  localparam logic [4:0] NGPR = 5'(NUM_GPR);

  logic [2:0]        state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] ar;
  logic [DATA_W-1:0] ac;
  logic              z;
  logic [7:0]        ir;
  logic [IMM_W-1:0]  imm_buf;
  logic [2:0]        imm_cnt;
  logic              imm_gap;

  logic [3:0]        op;
  logic [3:0]        n;
  logic              n_ok;
  logic              illegal;
  logic [2:0]        dec_nxt;
  logic [2:0]        imm_last;
  logic [DATA_W-1:0] rd_data;
  logic [DATA_W-1:0] alu_res;
  logic              rf_we;
  logic [DATA_W-1:0] rf_wdata;

  assign op       = ir[7:4];
  assign n        = ir[3:0];
  assign n_ok     = {1'b0, n} < NGPR;
  assign imm_last = (op == OP_LDI) ? 3'(IMM_BYTES) : 3'd2;

  // Illegal instructions are routed to HALT straight from DECODE so no state is touched.
  always_comb begin
    illegal = 1'b0;
    dec_nxt = ST_EXEC;
    case (op)
      OP_LDAR, OP_ST, OP_LD, OP_ADD, OP_SUB, OP_MUL, OP_INC: illegal = !n_ok;
      OP_MEM: begin
        if (n == SUB_LOAD || n == SUB_STORE) dec_nxt = ST_MEM;
        else if (n != SUB_INCAR) illegal = 1'b1;
      end
      OP_LDI, OP_JZ, OP_JNZ, OP_JMP: dec_nxt = ST_IMM;
      OP_ERR:  illegal = 1'b1;
      OP_HALT: dec_nxt = ST_HALT;
      default: ;
    endcase
    if (illegal) dec_nxt = ST_HALT;
  end

  always_comb begin
    case (alu_sel(op))
      ALU_ADD: alu_res = ac + rd_data;
      ALU_SUB: alu_res = ac - rd_data;
      ALU_MUL: alu_res = ac * rd_data;
      default: alu_res = (op == OP_CID) ? DATA_W'(core_id) : rd_data;
    endcase
  end

  assign rf_we    = (state == ST_EXEC) && (op == OP_ST || op == OP_INC);
  assign rf_wdata = (op == OP_ST) ? ac : rd_data + 1'b1;

  core_gen2_regfile #(
    .DATA_W (DATA_W),
    .NUM_GPR(NUM_GPR),
    .AW     (GPR_AW)
  ) u_regfile (
    .clk  (clk),
    .rst_n(rst_n),
    .we   (rf_we),
    .waddr(n[GPR_AW-1:0]),
    .wdata(rf_wdata),
    .raddr(n[GPR_AW-1:0]),
    .rdata(rd_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      pc      <= '0;
      ar      <= '0;
      ac      <= '0;
      z       <= 1'b1;
      err     <= 1'b0;
      ir      <= '0;
      imm_buf <= '0;
      imm_cnt <= '0;
      imm_gap <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            pc    <= '0;
            state <= ST_FETCH;
          end
        end
        ST_HALT: begin
          if (start) begin
            pc    <= '0;
            err   <= 1'b0;
            state <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          if (im_ack) begin
            ir    <= im_rdata;
            pc    <= pc + 1'b1;
            state <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          imm_buf <= '0;
          imm_cnt <= '0;
          imm_gap <= 1'b0;
          if (illegal) err <= 1'b1;
          state <= dec_nxt;
        end
        // Each operand byte is a request phase followed by a req-low gap; the
        // gap after the final byte commits the result.
        ST_IMM: begin
          if (imm_gap) begin
            imm_gap <= 1'b0;
            if (imm_cnt == imm_last) begin
              state <= ST_FETCH;
              case (op)
                OP_LDI: begin
                  ac <= imm_buf[DATA_W-1:0];
                  z  <= (imm_buf[DATA_W-1:0] == '0);
                end
                OP_JMP: pc <= imm_buf[ADDR_W-1:0];
                OP_JZ:  if (z)  pc <= imm_buf[ADDR_W-1:0];
                OP_JNZ: if (!z) pc <= imm_buf[ADDR_W-1:0];
                default: ;
              endcase
            end
          end else if (im_ack) begin
            imm_buf[{imm_cnt[1:0], 3'b000} +: 8] <= im_rdata;
            imm_cnt <= imm_cnt + 1'b1;
            pc      <= pc + 1'b1;
            imm_gap <= 1'b1;
          end
        end
        ST_EXEC: begin
          state <= ST_FETCH;
          case (op)
            OP_LDAR: ar <= ADDR_W'(rd_data);
            OP_MEM:  ar <= ar + 1'b1;
            OP_LD, OP_ADD, OP_SUB, OP_MUL, OP_CID: begin
              ac <= alu_res;
              z  <= (alu_res == '0);
            end
            default: ;
          endcase
        end
        ST_MEM: begin
          if (dm_ack) begin
            if (!ir[0]) begin
              ac <= dm_rdata;
              z  <= (dm_rdata == '0);
            end
            state <= ST_FETCH;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign im_req   = (state == ST_FETCH) || (state == ST_IMM && !imm_gap);
  assign im_addr  = pc;
  assign dm_req   = (state == ST_MEM);
  assign dm_we    = (state == ST_MEM) && ir[0];
  assign dm_addr  = ar;
  assign dm_wdata = ac;
  assign halted   = (state == ST_HALT);

endmodule
